// File: rtl/share_reporter_if.sv
// Result-interface bundle between the miner core and the share reporter.
// The miner drives hits (master); the reporter drives the UART line and status (slave).
interface share_reporter_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic           hit_valid;
    logic [31:0]    hit_nonce;
    logic [255:0]   hit_hash;
    logic           tx;
    logic           busy;
    logic [CW-1:0]  fifo_count;
    logic           overflow;
    logic [15:0]    frames_sent;

    modport master (
        output hit_valid, hit_nonce, hit_hash,
        input  tx, busy, fifo_count, overflow, frames_sent
    );

    modport slave (
        input  hit_valid, hit_nonce, hit_hash,
        output tx, busy, fifo_count, overflow, frames_sent
    );
endinterface

// File: rtl/share_reporter.sv
// Buffers miner hits in a small FIFO and streams each one to the host as a
// 38-byte 8N1 UART frame: A5, nonce (4 bytes), hash (32 bytes), XOR checksum.
module share_reporter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clock,
    input  logic              reset,
    share_reporter_if.slave   rep
);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = AW + 1;
    localparam int TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LAST_BYTE = 37;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t         state_q, state_d;
    logic [287:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           overflow_q;
    logic [287:0]   hold_q, hold_d;
    logic [7:0]     csum_q, csum_d;
    logic [7:0]     byte_q, byte_d;
    logic [5:0]     byte_idx_q, byte_idx_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           tx_q, tx_d;
    logic [15:0]    frames_q, frames_d;

    logic full, pop, push, bit_done;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = (state_q == IDLE) && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = rep.hit_valid && (!full || pop);
    assign bit_done = (timer_q == TW'(CLKS_PER_BIT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (rep.hit_valid && !push) overflow_q <= 1'b1;
        end
    end

    // NOTE: the entry storage has no reset; validity is carried by the pointers
    // and count, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= {rep.hit_nonce, rep.hit_hash};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            csum_q     <= '0;
            byte_q     <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            timer_q    <= '0;
            tx_q       <= 1'b1;
            frames_q   <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            csum_q     <= csum_d;
            byte_q     <= byte_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            timer_q    <= timer_d;
            tx_q       <= tx_d;
            frames_q   <= frames_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        csum_d     = csum_q;
        byte_d     = byte_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        timer_d    = timer_q;
        frames_d   = frames_q;
        tx_d       = 1'b1;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    hold_d     = mem[rd_ptr_q];
                    csum_d     = '0;
                    byte_idx_d = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                timer_d   = '0;
                bit_idx_d = '0;
                if (byte_idx_q == 6'd0) begin
                    byte_d = SYNC_BYTE;
                end else if (byte_idx_q == 6'(LAST_BYTE)) begin
                    byte_d = csum_q;
                end else begin
                    byte_d = hold_q[287:280];
                    hold_d = {hold_q[279:0], 8'h00};
                    csum_d = csum_q ^ hold_q[287:280];
                end
                state_d = START;
            end
            START: begin
                tx_d = 1'b0;
                if (bit_done) begin
                    timer_d = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                tx_d = byte_q[bit_idx_q];
                if (bit_done) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    timer_d = '0;
                    if (byte_idx_q < 6'(LAST_BYTE)) begin
                        byte_idx_d = byte_idx_q + 6'd1;
                        state_d    = LOAD;
                    end else begin
                        frames_d = frames_q + 16'd1;
                        state_d  = IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is registered so the pin is glitch-free; it trails the FSM by one cycle.
    assign rep.tx          = tx_q;
    assign rep.busy        = (state_q != IDLE) || (count_q != '0);
    assign rep.fifo_count  = count_q;
    assign rep.overflow    = overflow_q;
    assign rep.frames_sent = frames_q;
endmodule

// File: tb/tb_share_reporter.sv
// Scoreboard bench for share_reporter: expected frame bytes are queued when a
// hit is driven and popped by a UART receiver model that watches tx.
module tb_share_reporter;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME_CYCLES = 38 * (10 * CPB + 1);

    typedef logic [7:0] byte_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    byte_t exp_q[$];

    share_reporter_if #(.FIFO_DEPTH(DEPTH)) rep ();

    share_reporter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .rep   (rep.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic byte_t csum_of(input logic [31:0] n, input logic [255:0] h);
        byte_t x = 8'h00;
        for (int i = 0; i < 4; i++)  x ^= n[i*8 +: 8];
        for (int i = 0; i < 32; i++) x ^= h[i*8 +: 8];
        return x;
    endfunction

    task automatic push_frame(input logic [31:0] n, input logic [255:0] h, input byte_t cs);
        exp_q.push_back(8'hA5);
        for (int i = 3; i >= 0; i--)  exp_q.push_back(n[i*8 +: 8]);
        for (int i = 31; i >= 0; i--) exp_q.push_back(h[i*8 +: 8]);
        exp_q.push_back(cs);
    endtask

    // One hit pulse; inputs are scrambled afterwards to prove capture-at-push.
    task automatic hit_pulse(input logic [31:0] n, input logic [255:0] h);
        @(negedge clock);
        rep.hit_valid = 1'b1;
        rep.hit_nonce = n;
        rep.hit_hash  = h;
        @(negedge clock);
        rep.hit_valid = 1'b0;
        rep.hit_nonce = ~n;
        rep.hit_hash  = ~h;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || rep.busy) && n < 12000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy"}, 32'(rep.busy), 32'd0);
        repeat (4) @(negedge clock);
    endtask

    task automatic count_low(input int cycles, output int lows);
        lows = 0;
        repeat (cycles) begin
            @(negedge clock);
            if (rep.tx !== 1'b1) lows++;
        end
    endtask

    // UART receiver: every bit must hold one value for exactly CPB samples.
    task automatic rx_byte();
        logic [9:0] bits = '0;
        bit shape_ok = 1'b1;
        bit aborted  = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (!aborted) begin
                    if (!(b == 0 && c == 0)) @(negedge clock);
                    if (reset) aborted = 1'b1;
                    else if (c == 0) bits[b] = rep.tx;
                    else if (rep.tx !== bits[b]) shape_ok = 1'b0;
                end
            end
        end
        if (!aborted) begin
            check("stop_bit", 32'(bits[9]), 32'd1);
            check("bit_shape", 32'(shape_ok), 32'd1);
            if (exp_q.size() == 0) check("unexpected_byte", 32'(bits[8:1]), 32'h100);
            else                   check("rx_byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (!reset && rep.tx === 1'b0) rx_byte();
        end
    end

    initial begin
        logic [31:0]  n2;
        logic [255:0] h2;
        int lows;

        rep.hit_valid = 1'b0;
        rep.hit_nonce = '0;
        rep.hit_hash  = '0;

        // Reset state and quiet line
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_tx", 32'(rep.tx), 32'd1);
        check("rst_busy", 32'(rep.busy), 32'd0);
        check("rst_count", 32'(rep.fifo_count), 32'd0);
        check("rst_ovf", 32'(rep.overflow), 32'd0);
        check("rst_frames", 32'(rep.frames_sent), 32'd0);
        count_low(100, lows);
        check("idle_quiet", 32'(lows), 32'd0);

        // Single frame with latency checks
        n2 = 32'h42A14695;
        h2 = 256'h0000_0000_00AB_CDEF_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6901;
        push_frame(n2, h2, csum_of(n2, h2));
        hit_pulse(n2, h2);                       // now just after edge N
        check("lat_count_n", 32'(rep.fifo_count), 32'd1);
        @(negedge clock);                        // after N+1: popped
        check("lat_count_n1", 32'(rep.fifo_count), 32'd0);
        check("lat_busy_n1", 32'(rep.busy), 32'd1);
        @(negedge clock);
        check("lat_tx_n2", 32'(rep.tx), 32'd1);
        @(negedge clock);
        check("lat_tx_n3", 32'(rep.tx), 32'd0);
        wait_idle("frame1");
        check("frames_1", 32'(rep.frames_sent), 32'd1);

        // Checksum corners
        push_frame(32'h0000_0000, 256'h0, 8'h00);
        hit_pulse(32'h0000_0000, 256'h0);
        push_frame(32'h0000_00FF, 256'h0, 8'hFF);
        hit_pulse(32'h0000_00FF, 256'h0);
        push_frame(32'hFFFF_FFFF, '1, 8'h00);
        hit_pulse(32'hFFFF_FFFF, '1);
        wait_idle("corners");
        check("frames_4", 32'(rep.frames_sent), 32'd4);
        check("ovf_none", 32'(rep.overflow), 32'd0);

        // Burst of 6 into a 4-deep FIFO: nonce 6 is dropped
        for (int i = 0; i < 5; i++) push_frame(32'(i + 1), {8{32'(i + 1)}}, csum_of(32'(i + 1), {8{32'(i + 1)}}));
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 2) check("burst_pop_n1", 32'(rep.fifo_count), 32'd1);
            if (i == 5) begin
                check("burst_peak", 32'(rep.fifo_count), 32'd4);
                check("burst_ovf_early", 32'(rep.overflow), 32'd0);
            end
            rep.hit_valid = 1'b1;
            rep.hit_nonce = 32'(i + 1);
            rep.hit_hash  = {8{32'(i + 1)}};
        end
        @(negedge clock);
        rep.hit_valid = 1'b0;
        check("burst_full", 32'(rep.fifo_count), 32'd4);
        check("burst_ovf", 32'(rep.overflow), 32'd1);
        wait_idle("burst");
        check("frames_9", 32'(rep.frames_sent), 32'd9);
        check("ovf_sticky", 32'(rep.overflow), 32'd1);

        // Reset in the middle of byte 10 with 2 entries queued
        for (int i = 0; i < 3; i++) push_frame(32'(i + 16), {8{32'(i + 16)}}, csum_of(32'(i + 16), {8{32'(i + 16)}}));
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            rep.hit_valid = 1'b1;
            rep.hit_nonce = 32'(i + 16);
            rep.hit_hash  = {8{32'(i + 16)}};
        end
        @(negedge clock);
        rep.hit_valid = 1'b0;
        check("midrst_queued", 32'(rep.fifo_count), 32'd2);
        repeat (420) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_tx", 32'(rep.tx), 32'd1);
        check("midrst_count", 32'(rep.fifo_count), 32'd0);
        check("midrst_frames", 32'(rep.frames_sent), 32'd0);
        check("midrst_ovf", 32'(rep.overflow), 32'd0);
        check("midrst_busy", 32'(rep.busy), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        count_low(200, lows);
        check("midrst_quiet", 32'(lows), 32'd0);

        // Push into a full FIFO on the very cycle IDLE pops it
        for (int i = 0; i < 6; i++) push_frame(32'(i + 32), {8{32'(i + 32)}}, csum_of(32'(i + 32), {8{32'(i + 32)}}));
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            rep.hit_valid = 1'b1;
            rep.hit_nonce = 32'(i + 32);
            rep.hit_hash  = {8{32'(i + 32)}};
        end
        @(negedge clock);                        // after N+4
        rep.hit_valid = 1'b0;
        check("pp_full", 32'(rep.fifo_count), 32'd4);
        repeat (FRAME_CYCLES + 2 - 5) @(negedge clock);   // after N+1559
        check("pp_before", 32'(rep.fifo_count), 32'd4);
        rep.hit_valid = 1'b1;
        rep.hit_nonce = 32'd37;
        rep.hit_hash  = {8{32'd37}};
        @(negedge clock);                        // after N+1560: pop + push
        rep.hit_valid = 1'b0;
        check("pp_count", 32'(rep.fifo_count), 32'd4);
        check("pp_ovf", 32'(rep.overflow), 32'd0);
        wait_idle("pushpop");
        check("frames_6", 32'(rep.frames_sent), 32'd6);
        check("pp_ovf_end", 32'(rep.overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
